// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the digit-serial subtractor
package serial_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/serial_sub_str_fourbit.sv
// rtl/serial_sub_str_fourbit.sv - combinational 4-bit ripple-borrow slice of full-subtractor cells
module fourbit_sub_str
  import serial_sub_pkg::*;
(
  output logic               Bout,
  output logic [SLICE_W-1:0] D,
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Bin
);

  logic [SLICE_W:0] w_borrow;

  assign w_borrow[0] = Bin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_cell
    assign D[i]            = A[i] ^ B[i] ^ w_borrow[i];
    assign w_borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
  end

  assign Bout = w_borrow[SLICE_W];

endmodule

// File: rtl/serial_sub_str.sv
// rtl/serial_sub_str.sv - digit-serial WIDTH-bit subtractor, one 4-bit slice per clock
// Optional add mode (op port) enabled by defining SERIAL_SUB_ADD_MODE_EN.
module serial_sub_str
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int N  = slice_count(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_d;
  logic               r_borrow, r_bout, r_ovf, r_in_ready, r_out_valid;
  logic [SLICE_W-1:0] w_sd;
  logic               w_sbout, w_accept, w_last, w_release, w_add;
  logic [WIDTH-1:0]   w_cap_b;
  logic               w_cap_bin;

  assign w_accept  = (r_state == IDLE) && r_in_ready && in_valid;
  assign w_last    = (r_state == RUN) && (r_cnt == CW'(N - 1));
  assign w_release = (r_state == DONE) && r_out_valid && out_ready;

`ifdef SERIAL_SUB_ADD_MODE_EN
  // A + B + Cin == A - ~B - ~Cin (mod 2^WIDTH); carry-out is the inverted borrow.
  logic r_op;
  assign w_add     = r_op;
  assign w_cap_b   = op ? ~B : B;
  assign w_cap_bin = Bin ^ op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_op <= 1'b0;
    else if (w_accept) r_op <= op;
  end
`else
  assign w_add     = 1'b0;
  assign w_cap_b   = B;
  assign w_cap_bin = Bin;
`endif

  fourbit_sub_str u_slice (
    .Bout (w_sbout),
    .D    (w_sd),
    .A    (r_a[SLICE_W-1:0]),
    .B    (r_b[SLICE_W-1:0]),
    .Bin  (r_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (w_release) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_a        <= A;
            r_b        <= w_cap_b;
            r_borrow   <= w_cap_bin;
            r_cnt      <= '0;
          end
        end
        RUN: begin
          // Result nibbles enter r_a from the top as operand nibbles leave the bottom.
          r_a      <= {w_sd, r_a[WIDTH-1:SLICE_W]};
          r_b      <= r_b >> SLICE_W;
          r_borrow <= w_sbout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_d         <= {w_sd, r_a[WIDTH-1:SLICE_W]};
            r_bout      <= w_sbout ^ w_add;
            // Borrow into the MSB recovered from the MSB sum bit.
            r_ovf       <= w_sd[SLICE_W-1] ^ r_a[SLICE_W-1] ^ r_b[SLICE_W-1] ^ w_sbout;
          end
        end
        DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign Bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
